// File: rtl/mcmult_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NREQ
// requesters. A grant latches the winner's operands onto the multiplier
// port, holds them for the mode's cycle count (plus any result latency)
// and returns the sampled product tagged with the requester index.
module mcmult_sched #(
  parameter int NREQ    = 2,
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int OW      = 16,
  parameter int RES_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_mode,
  input  logic [N*NREQ-1:0]        req_a,
  input  logic [M*NREQ-1:0]        req_b,
  output logic                     mul_start,
  output logic [1:0]               mul_mode,
  output logic [N-1:0]             mul_a,
  output logic [M-1:0]             mul_b,
  input  logic [OW-1:0]            mul_out,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [OW-1:0]            resp_data,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  // Wide enough to hold RES_LAT, and at least one bit when RES_LAT is 0.
  localparam int WW = $clog2(RES_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t          state_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [IW-1:0]   id_reg;
  logic [2:0]      cnt_reg;
  logic [WW-1:0]   wcnt_reg;

  logic [N-1:0]    a_arr    [NREQ];
  logic [M-1:0]    b_arr    [NREQ];
  logic [1:0]      mode_arr [NREQ];

  logic [IW-1:0]   grant_idx;
  logic            grant_found;

  // Split the flat per-requester buses into indexable arrays.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]    = req_a[gi*N +: N];
    assign b_arr[gi]    = req_b[gi*M +: M];
    assign mode_arr[gi] = req_mode[gi*2 +: 2];
  end

  // Mode 00 is one cycle, 01 is two, both 1x encodings run the full 8x8.
  function automatic logic [2:0] cyc_of(input logic [1:0] m);
    case (m)
      2'b00:   cyc_of = 3'd1;
      2'b01:   cyc_of = 3'd2;
      default: cyc_of = 3'd4;
    endcase
  endfunction

  // Scan from the requester after the last winner, wrapping, and pick the
  // first valid one; only offered while idle and out of reset.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    if (state_reg == IDLE && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(rr_ptr_reg) + k) % NREQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = IW'(idx);
        end
      end
    end
    req_ready = grant_found ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  assign busy = (state_reg != IDLE);

  // Operation sequencer: grant, hold operands through RUN, wait out the
  // result latency, then emit a one-cycle tagged response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= IW'(NREQ - 1);
      id_reg     <= '0;
      cnt_reg    <= '0;
      wcnt_reg   <= '0;
      mul_start  <= 1'b0;
      mul_mode   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      mul_start  <= 1'b0;
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            rr_ptr_reg <= grant_idx;
            id_reg     <= grant_idx;
            mul_a      <= a_arr[grant_idx];
            mul_b      <= b_arr[grant_idx];
            mul_mode   <= mode_arr[grant_idx];
            mul_start  <= 1'b1;
            cnt_reg    <= cyc_of(mode_arr[grant_idx]);
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (cnt_reg == 3'd1) begin
            if (RES_LAT == 0) begin
              resp_valid <= 1'b1;
              resp_data  <= mul_out;
              resp_id    <= id_reg;
              state_reg  <= IDLE;
            end else begin
              wcnt_reg   <= WW'(RES_LAT);
              state_reg  <= WAIT;
            end
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        WAIT: begin
          if (wcnt_reg == WW'(1)) begin
            resp_valid <= 1'b1;
            resp_data  <= mul_out;
            resp_id    <= id_reg;
            state_reg  <= IDLE;
          end else begin
            wcnt_reg <= wcnt_reg - WW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcmult_sched.sv
// Bench for mcmult_sched: one instance on a bare combinational multiplier
// model (RES_LAT=0) and one on a flopped-I/O wrapper model (RES_LAT=2).
module tb_mcmult_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT with bare multiplier
  logic [1:0]  req_valid0 = '0, req_ready0;
  logic [3:0]  req_mode0  = '0;
  logic [15:0] req_a0     = '0, req_b0 = '0;
  logic        mul_start0, resp_valid0, busy0;
  logic [1:0]  mul_mode0;
  logic [7:0]  mul_a0, mul_b0;
  logic [15:0] mul_out0, resp_data0;
  logic [0:0]  resp_id0;

  // DUT with flopped-I/O wrapper
  logic [1:0]  req_valid2 = '0, req_ready2;
  logic [3:0]  req_mode2  = '0;
  logic [15:0] req_a2     = '0, req_b2 = '0;
  logic        mul_start2, resp_valid2, busy2;
  logic [1:0]  mul_mode2;
  logic [7:0]  mul_a2, mul_b2;
  logic [15:0] mul_out2, resp_data2;
  logic [0:0]  resp_id2;

  // Multiplier model: 4x4 uses the low nibbles, 4x8 the low nibble of A.
  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] m);
    case (m)
      2'b00:   prod = 16'(a[3:0]) * 16'(b[3:0]);
      2'b01:   prod = 16'(a[3:0]) * 16'(b);
      default: prod = 16'(a) * 16'(b);
    endcase
  endfunction

  assign mul_out0 = prod(mul_a0, mul_b0, mul_mode0);

  logic [7:0]  w_a = '0, w_b = '0;
  logic [1:0]  w_m = '0;
  logic [15:0] w_out = '0;
  always_ff @(posedge clk) begin
    w_a   <= mul_a2;
    w_b   <= mul_b2;
    w_m   <= mul_mode2;
    w_out <= prod(w_a, w_b, w_m);
  end
  assign mul_out2 = w_out;

  mcmult_sched #(.NREQ(2), .N(8), .M(8), .OW(16), .RES_LAT(0)) d0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_mode(req_mode0), .req_a(req_a0), .req_b(req_b0),
    .mul_start(mul_start0), .mul_mode(mul_mode0), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_out(mul_out0), .resp_valid(resp_valid0), .resp_id(resp_id0),
    .resp_data(resp_data0), .busy(busy0));

  mcmult_sched #(.NREQ(2), .N(8), .M(8), .OW(16), .RES_LAT(2)) d2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_mode(req_mode2), .req_a(req_a2), .req_b(req_b2),
    .mul_start(mul_start2), .mul_mode(mul_mode2), .mul_a(mul_a2), .mul_b(mul_b2),
    .mul_out(mul_out2), .resp_valid(resp_valid2), .resp_id(resp_id2),
    .resp_data(resp_data2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req0(input int id, input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] b);
    req_mode0[id*2 +: 2] = m;
    req_a0[id*8 +: 8]    = a;
    req_b0[id*8 +: 8]    = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    int          id;
    int          cyc;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nresp;
    vecs[0] = '{2'b00, 8'h03, 8'h05, 0, 1, 16'h000F};
    vecs[1] = '{2'b10, 8'h12, 8'h34, 1, 4, 16'h03A8};
    vecs[2] = '{2'b01, 8'h0B, 8'hC8, 0, 2, 16'h0898};
    vecs[3] = '{2'b11, 8'hFF, 8'hFF, 1, 4, 16'hFE01};
    vecs[4] = '{2'b00, 8'h1F, 8'h2E, 0, 1, 16'h00D2};

    // Reset values, with requests pending during reset
    req_valid0 = 2'b11;
    req_valid2 = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(req_ready0), 0);
    check("rst_ready2", 32'(req_ready2), 0);
    check("rst_outs0", {mul_start0, mul_mode0, mul_a0, mul_b0, resp_valid0, resp_id0, busy0}, 0);
    check("rst_data0", 32'(resp_data0), 0);
    check("rst_outs2", {mul_start2, mul_mode2, mul_a2, mul_b2, resp_valid2, resp_id2, busy2}, 0);
    @(posedge clk); #1;
    req_valid0 = '0;
    req_valid2 = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table: single requests on the bare multiplier
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      set_req0(vecs[v].id, vecs[v].mode, vecs[v].a, vecs[v].b);
      req_valid0 = 2'(1 << vecs[v].id);
      @(negedge clk);
      check($sformatf("v%0d_ready", v), 32'(req_ready0), 32'(1 << vecs[v].id));
      check($sformatf("v%0d_busy0", v), 32'(busy0), 0);
      @(posedge clk); #1 req_valid0 = '0;
      for (int c = 1; c <= vecs[v].cyc + 1; c++) begin
        @(negedge clk);
        check($sformatf("v%0d_c%0d_start", v, c), 32'(mul_start0), 32'(c == 1));
        if (c <= vecs[v].cyc) begin
          check($sformatf("v%0d_c%0d_ops", v, c), {mul_mode0, mul_a0, mul_b0},
                {vecs[v].mode, vecs[v].a, vecs[v].b});
          check($sformatf("v%0d_c%0d_busy", v, c), 32'(busy0), 1);
          check($sformatf("v%0d_c%0d_rv", v, c), 32'(resp_valid0), 0);
        end else begin
          check($sformatf("v%0d_rv", v), 32'(resp_valid0), 1);
          check($sformatf("v%0d_id", v), 32'(resp_id0), 32'(vecs[v].id));
          check($sformatf("v%0d_data", v), 32'(resp_data0), 32'(vecs[v].prod));
          check($sformatf("v%0d_idle", v), 32'(busy0), 0);
        end
      end
      @(negedge clk);
      check($sformatf("v%0d_rv_once", v), 32'(resp_valid0), 0);
      check($sformatf("v%0d_hold", v), {mul_mode0, mul_a0, mul_b0},
            {vecs[v].mode, vecs[v].a, vecs[v].b});
    end

    // Two requesters held valid, mode 01: period 3, alternating grants
    do_reset();
    set_req0(0, 2'b01, 8'h02, 8'h03);
    set_req0(1, 2'b01, 8'h04, 8'h05);
    @(posedge clk); #1 req_valid0 = 2'b11;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("rr_c%0d_ready", c), 32'(req_ready0),
            (c % 3 == 0 && c <= 9) ? 32'(1 << ((c / 3) % 2)) : 0);
      check($sformatf("rr_c%0d_start", c), 32'(mul_start0), 32'(c % 3 == 1 && c <= 10));
      check($sformatf("rr_c%0d_rv", c), 32'(resp_valid0), 32'(c % 3 == 0 && c >= 3));
      if (c % 3 == 0 && c >= 3) begin
        check($sformatf("rr_c%0d_id", c), 32'(resp_id0), 32'(((c / 3) - 1) % 2));
        check($sformatf("rr_c%0d_data", c), 32'(resp_data0), (((c / 3) - 1) % 2) ? 20 : 6);
      end
      if (c == 9) begin
        @(posedge clk); #1 req_valid0 = '0;
      end
    end

    // RES_LAT=2 wrapper: WAIT cycles 2-3, response and regrant at cycle 4
    req_mode2 = 4'b0000;
    req_a2    = 16'h0007;
    req_b2    = 16'h0009;
    @(posedge clk); #1 req_valid2 = 2'b01;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("lat_c%0d_ready", c), 32'(req_ready2), (c == 0 || c == 4) ? 1 : 0);
      check($sformatf("lat_c%0d_start", c), 32'(mul_start2), 32'(c == 1));
      check($sformatf("lat_c%0d_busy", c), 32'(busy2), 32'(c >= 1 && c <= 3));
      check($sformatf("lat_c%0d_rv", c), 32'(resp_valid2), 32'(c == 4));
      if (c == 4) begin
        check("lat_data", 32'(resp_data2), 63);
        check("lat_id", 32'(resp_id2), 0);
      end
    end
    @(posedge clk); #1 req_valid2 = '0;
    repeat (6) @(posedge clk);

    // Reset mid 8x8 operation; req1 pending is served after reset
    do_reset();
    set_req0(0, 2'b10, 8'h55, 8'h66);
    set_req0(1, 2'b00, 8'h02, 8'h03);
    @(posedge clk); #1 req_valid0 = 2'b11;
    @(negedge clk);
    check("abort_c0_ready", 32'(req_ready0), 1);
    @(posedge clk); #1 req_valid0 = 2'b10;
    @(negedge clk);
    check("abort_c1_start", 32'(mul_start0), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_c2_ready", 32'(req_ready0), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_c3_busy", 32'(busy0), 0);
    check("abort_c3_start", 32'(mul_start0), 0);
    check("abort_c3_rv", 32'(resp_valid0), 0);
    check("abort_c3_ready", 32'(req_ready0), 2);
    @(posedge clk); #1 req_valid0 = '0;
    nresp = 0;
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("abort_c5_rv", 32'(resp_valid0), 1);
        check("abort_c5_id", 32'(resp_id0), 1);
        check("abort_c5_data", 32'(resp_data0), 6);
      end
      if (resp_valid0) nresp++;
    end
    check("abort_resp_count", 32'(nresp), 1);

    // req1 raised during a req0 4x4 op: granted alongside req0's response
    do_reset();
    set_req0(0, 2'b00, 8'h04, 8'h06);
    set_req0(1, 2'b00, 8'h05, 8'h05);
    @(posedge clk); #1 req_valid0 = 2'b01;
    @(negedge clk);
    check("ovl_c0_ready", 32'(req_ready0), 1);
    @(posedge clk); #1 req_valid0 = 2'b10;
    @(negedge clk);
    check("ovl_c1_ready", 32'(req_ready0), 0);
    check("ovl_c1_start", 32'(mul_start0), 1);
    @(negedge clk);
    check("ovl_c2_ready", 32'(req_ready0), 2);
    check("ovl_c2_resp", {resp_valid0, resp_id0, resp_data0}, {1'b1, 1'b0, 16'd24});
    @(posedge clk); #1 req_valid0 = '0;
    @(negedge clk);
    check("ovl_c3_start", {mul_start0, mul_a0, mul_b0}, {1'b1, 8'h05, 8'h05});
    @(negedge clk);
    check("ovl_c4_resp", {resp_valid0, resp_id0, resp_data0}, {1'b1, 1'b1, 16'd25});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
